seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Stimulus generator that drives the `x` / `y` / `z` pattern described by the parameterised sequence `x ##d1 y[*n] ##d2 z`. Delays and repeat count are runtime-programmable. It is the producing end of the sequence checks in the assertion test suite: benches instantiate it to drive signals that the sequence/property assertions must accept. Errors in its output are therefore reported as assertion failures.

## Interface
Parameters:
- `CNT_W`, 8: width of the `delay1`, `rep` and `delay2` fields and of the internal counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to run one pattern; sampled only in IDLE.
- `abort`, input, 1: synchronous abort of a running pattern.
- `delay1`, input, CNT_W: cycles from `x` to the first `y`; must be ≥1.
- `rep`, input, CNT_W: number of consecutive `y` cycles; must be ≥1.
- `delay2`, input, CNT_W: cycles from the last `y` to `z`; must be ≥1.
- `busy`, output, 1: high while a pattern is in progress.
- `done`, output, 1: one-cycle pulse, coincident with `z`.
- `cfg_err`, output, 1: one-cycle pulse when `start` is presented with an illegal configuration.
- `x`, output, 1: pattern signal.
- `y`, output, 1: pattern signal.
- `z`, output, 1: pattern signal.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset puts the FSM in IDLE with the counter at 0.
- FSM states: IDLE, X, GAP1, Y, GAP2, Z.
- IDLE, `start`=1, all three fields ≥1:
  - Latch `delay1`, `rep` and `delay2`.
  - Go to X.
- IDLE, `start`=1, any field =0:
  - Pulse `cfg_err` for one cycle.
  - Stay in IDLE; no pattern is driven.
- X: `x`=1 for exactly 1 cycle.
  - Next state is GAP1 if `delay1`>1, else Y.
  - Counter loads `delay1`-1 for GAP1.
- GAP1: all pattern outputs 0 for `delay1`-1 cycles, then Y.
- Y: `y`=1 for `rep` consecutive cycles.
  - Then GAP2 if `delay2`>1, else Z.
- GAP2: all pattern outputs 0 for `delay2`-1 cycles, then Z.
- Z: `z`=1 and `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Only one pattern output is high in any cycle.
- `start` while busy is ignored. It is not queued.
- `abort`=1 in any non-IDLE state:
  - Next cycle: IDLE, all outputs 0, no `done`.
  - `abort` has priority over every normal transition.
  - `abort` in IDLE has no effect.
- `start` and `abort` together in IDLE: `start` is honoured.
- Input fields are latched at start. Changes to them mid-run have no effect.
- Counter: one shared down-counter of width CNT_W, loaded on each state entry. Maximum values (2^CNT_W−1) must work with no wrap.

## Timing
- `start` sampled at edge 0.
- `x` high in cycle 1.
- First `y` in cycle 1+`delay1`.
- Last `y` in cycle `delay1`+`rep`.
- `z`/`done` in cycle `delay1`+`rep`+`delay2`.
- IDLE again in the following cycle. The earliest next `start` is accepted in the cycle after `z`.
- `cfg_err` is asserted in cycle 1 after the offending `start`.
- Reset assertion mid-pattern clears all outputs immediately (asynchronous), without waiting for a clock edge.

## Structure
- Package `seq_gen_pkg`:
  - state enum `seq_state_e`;
  - `localparam` default `CNT_W`;
  - function `cfg_ok(delay1, rep, delay2)`.
- Sub-module `seq_gen_cnt`: loadable down-counter with a `zero` flag, instantiated once.
- Everything else lives in `seq_pattern_gen`.

## Test plan
- **Nominal run.** `delay1`=2, `rep`=3, `delay2`=1, `start` at cycle 0.
  - `x`@1; `y`@3,4,5; `z`/`done`@6; `busy` covers 1–6.
  - The bound assertion `x ##2 y[*3] ##1 z` passes.
- **Minimum values.** 1/1/1.
  - `x`@1, `y`@2, `z`@3.
  - The assertion `x ##1 y ##1 z` passes.
- **Illegal configuration.** `rep`=0 with `start`.
  - `cfg_err` pulse at cycle 1.
  - `busy`, `x`, `y`, `z` stay 0.
- **Abort.** Run 4/3/2 and assert `abort` at cycle 3 (GAP1).
  - From cycle 4: IDLE with all outputs 0.
  - No `y`, no `z`, no `done`.
- **Ignored inputs while busy.** Re-assert `start` and change `delay1` during a 2/3/1 run.
  - Original timing is unchanged.
  - No second pattern.
- **Mid-pattern reset.** Drop `rst_n` during Y.
  - Outputs go to 0 asynchronously.
  - After release, a new 2/3/1 run times exactly as in the nominal case.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the x ##d1 y[*n] ##d2 z stimulus generator.
package seq_gen_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_X,
        ST_GAP1,
        ST_Y,
        ST_GAP2,
        ST_Z
    } seq_state_e;

    // Callers zero-extend their fields to 32 bits so one helper serves every CNT_W.
    function automatic logic cfg_ok(input logic [31:0] delay1,
                                    input logic [31:0] rep,
                                    input logic [31:0] delay2);
        return (delay1 != 32'd0) && (rep != 32'd0) && (delay2 != 32'd0);
    endfunction

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter shared by all timed states; stops at zero and flags it.
module seq_gen_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Drives x ##delay1 y[*rep] ##delay2 z with runtime-programmable timing; all outputs registered.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay1,
    input  logic [CNT_W-1:0] rep,
    input  logic [CNT_W-1:0] delay2,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             x,
    output logic             y,
    output logic             z
);

    seq_state_e       state, state_d;
    logic [CNT_W-1:0] d1_q, rep_q, d2_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             start_ok;
    logic             accept;

    assign start_ok = cfg_ok(32'(delay1), 32'(rep), 32'(delay2));
    assign accept   = (state == ST_IDLE) && start && start_ok;

    seq_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Counter is loaded with (duration - 1) on state entry; the state exits once it reads zero.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (state != ST_IDLE && abort) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_d  = ST_X;
                        cnt_load = 1'b1;
                    end
                end
                ST_X: begin
                    cnt_load = 1'b1;
                    if (d1_q > CNT_W'(1)) begin
                        state_d = ST_GAP1;
                        cnt_val = d1_q - CNT_W'(2);
                    end else begin
                        state_d = ST_Y;
                        cnt_val = rep_q - CNT_W'(1);
                    end
                end
                ST_GAP1: begin
                    if (cnt_zero) begin
                        state_d  = ST_Y;
                        cnt_load = 1'b1;
                        cnt_val  = rep_q - CNT_W'(1);
                    end
                end
                ST_Y: begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        if (d2_q > CNT_W'(1)) begin
                            state_d = ST_GAP2;
                            cnt_val = d2_q - CNT_W'(2);
                        end else begin
                            state_d = ST_Z;
                        end
                    end
                end
                ST_GAP2: begin
                    if (cnt_zero) begin
                        state_d  = ST_Z;
                        cnt_load = 1'b1;
                    end
                end
                ST_Z: begin
                    state_d  = ST_IDLE;
                    cnt_load = 1'b1;
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            d1_q  <= '0;
            rep_q <= '0;
            d2_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                d1_q  <= delay1;
                rep_q <= rep;
                d2_q  <= delay2;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            x       <= 1'b0;
            y       <= 1'b0;
            z       <= 1'b0;
        end else begin
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_Z);
            cfg_err <= (state == ST_IDLE) && start && !start_ok;
            x       <= (state_d == ST_X);
            y       <= (state_d == ST_Y);
            z       <= (state_d == ST_Z);
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; outputs sampled mid-cycle on the falling edge.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] delay1;
    logic [7:0] rep;
    logic [7:0] delay2;
    logic       busy, done, cfg_err, x, y, z;
    logic [5:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .delay1  (delay1),
        .rep     (rep),
        .delay2  (delay2),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err),
        .x       (x),
        .y       (y),
        .z       (z)
    );

    assign obs = {busy, done, cfg_err, x, y, z};

    // Expected {busy,done,cfg_err,x,y,z} in cycle c after a legal start sampled at edge 0.
    function automatic logic [5:0] model(input int c, input int d1, input int r, input int d2);
        logic bsy, xx, yy, zz;
        bsy = (c >= 1) && (c <= d1 + r + d2);
        xx  = (c == 1);
        yy  = (c > d1) && (c <= d1 + r);
        zz  = (c == d1 + r + d2);
        return {bsy, zz, 1'b0, xx, yy, zz};
    endfunction

    // Presents start for exactly one rising edge (edge 0); returns in the middle of cycle 1.
    task automatic issue_start(input int d1, input int r, input int d2);
        @(negedge clk);
        delay1 = 8'(d1);
        rep    = 8'(r);
        delay2 = 8'(d2);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", obs, 6'b0);
        end
    endtask

    task automatic test_pattern(input string name, input int d1, input int r, input int d2);
        logic [5:0] exp_v;
        issue_start(d1, r, d2);
        for (int c = 1; c <= d1 + r + d2 + 2; c++) begin
            if (c > 1) @(negedge clk);
            exp_v = model(c, d1, r, d2);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, obs, exp_v);
            end
        end
    endtask

    task automatic test_cfg_err();
        int cfg [3][3] = '{'{0, 3, 1}, '{2, 0, 1}, '{2, 3, 0}};
        logic [5:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            issue_start(cfg[k][0], cfg[k][1], cfg[k][2]);
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) @(negedge clk);
                exp_v = (c == 1) ? 6'b001000 : 6'b000000;
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL cfg_err_%0d cycle %0d: got %b expected %b", k, c, obs, exp_v);
                end
            end
        end
    endtask

    // Start and abort together in IDLE: start wins. Abort again in GAP1 kills the run.
    task automatic test_abort();
        logic [5:0] exp_v;
        @(negedge clk);
        delay1 = 8'd4;
        rep    = 8'd3;
        delay2 = 8'd2;
        start  = 1'b1;
        abort  = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            exp_v = (c <= 3) ? model(c, 4, 3, 2) : 6'b000000;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 3) abort = 1'b1;
            if (c == 4) abort = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        logic [5:0] exp_v;
        @(negedge clk);
        delay1 = 8'd2;
        rep    = 8'd3;
        delay2 = 8'd1;
        start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp_v = model(c, 2, 3, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ignore_busy cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 1) begin
                delay1 = 8'd7;
                rep    = 8'd5;
            end
            if (c == 7) start = 1'b0;
        end
    endtask

    // Start held high: edges inside the run are ignored, the edge in the cycle after z is taken.
    task automatic test_back_to_back();
        logic [5:0] exp_v;
        @(negedge clk);
        delay1 = 8'd1;
        rep    = 8'd1;
        delay2 = 8'd1;
        start  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 3)      exp_v = model(c, 1, 1, 1);
            else if (c == 4) exp_v = 6'b000000;
            else             exp_v = model(c - 4, 1, 1, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 5) start = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        issue_start(2, 3, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 6'b100010) begin
            errors++;
            $display("FAIL mid_reset_in_y: got %b expected %b", obs, 6'b100010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL mid_reset_async_clear: got %b expected %b", obs, 6'b000000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_pattern("after_reset", 2, 3, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        delay1 = '0;
        rep    = '0;
        delay2 = '0;
        test_reset();
        test_pattern("nominal", 2, 3, 1);
        test_pattern("minimum", 1, 1, 1);
        test_pattern("gap2", 3, 1, 4);
        test_cfg_err();
        test_abort();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        test_pattern("max", 255, 255, 255);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
